// File: rtl/meter_pkg.sv
// Shared types and helpers for the per-channel peak level meter.
package meter_pkg;

  // Width of one quantised level field in the published word.
  localparam int unsigned LEVEL_W = 4;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    COMMIT  = 2'd1,
    PUBLISH = 2'd2
  } meter_state_t;

  // Saturating magnitude of a sign-extended w-bit sample (w <= 32): the most
  // negative w-bit value maps to the largest positive w-bit value.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
    logic [31:0] mag;
    logic [31:0] lim;
    lim = (32'd1 << (w - 1)) - 32'd1;
    mag = x[31] ? 32'(-x) : 32'(x);
    if (mag > lim) mag = lim;
    return mag;
  endfunction

endpackage

// File: rtl/level_quantizer.sv
// Log quantiser: 0 for a zero peak, else 1 + index of the most significant set bit.
module level_quantizer
  import meter_pkg::*;
(
  input  logic [14:0]        peak_i,
  output logic [LEVEL_W-1:0] level_o
);

  // Priority encode; the highest set bit wins because it is visited last.
  always_comb begin
    level_o = '0;
    for (int i = 0; i < 15; i++) begin
      if (peak_i[i]) level_o = LEVEL_W'(i + 1);
    end
  end

endmodule

// File: rtl/level_meter.sv
// Folds a channel-multiplexed sample stream into per-channel peaks, and once per
// video frame turns them into 4-bit log levels with fall-off ballistics.
module level_meter
  import meter_pkg::*;
#(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [2:0]          sample_ch,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [31:0]         sound_data,
  output logic                level_valid,
  output logic                overrun
);

  localparam int unsigned DCNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [2:0]                sync_q;
  logic                      frame_edge;
  meter_state_t              state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [14:0]               peak_q [NUM_CH];
  logic [14:0]               peak_d [NUM_CH];
  logic [LEVEL_W-1:0]        lvl_q  [NUM_CH];
  logic [LEVEL_W-1:0]        lvl_d  [NUM_CH];
  logic [DCNT_W-1:0]         dcnt_q [NUM_CH];
  logic [DCNT_W-1:0]         dcnt_d [NUM_CH];
  logic [31:0]               sound_q;
  logic [31:0]               packed_lvl;
  logic                      overrun_q;
  logic                      accept;
  logic [31:0]               mag;
  logic [31:0]               shifted;
  logic [14:0]               m15;
  logic [LEVEL_W-1:0]        q_level;
  logic                      unused_shifted;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], frame_clk};
  end

  assign frame_edge   = sync_q[1] & ~sync_q[2];
  assign sample_ready = (state_q == ACCUM);
  assign accept       = sample_valid && sample_ready;

  assign mag            = sat_abs(32'(signed'(sample_data)), SAMPLE_W);
  assign shifted        = mag >> (SAMPLE_W - 16);
  assign m15            = shifted[14:0];
  assign unused_shifted = ^shifted[31:15];

  level_quantizer u_quant (
    .peak_i  (peak_q[idx_q]),
    .level_o (q_level)
  );

  // Frame sequencing: accumulate, commit one channel per cycle, publish.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ACCUM: begin
        if (frame_edge) begin
          state_d = COMMIT;
          idx_d   = '0;
        end
      end
      COMMIT: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(NUM_CH - 1)) begin
          state_d = PUBLISH;
          idx_d   = '0;
        end
      end
      PUBLISH: state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Peak folding in ACCUM; level/decay update and peak clear in COMMIT.
  always_comb begin
    peak_d = peak_q;
    lvl_d  = lvl_q;
    dcnt_d = dcnt_q;
    if (accept && (m15 > peak_q[sample_ch])) peak_d[sample_ch] = m15;
    if (state_q == COMMIT) begin
      if (q_level >= lvl_q[idx_q]) begin
        lvl_d[idx_q]  = q_level;
        dcnt_d[idx_q] = '0;
      end else if (dcnt_q[idx_q] == DCNT_W'(DECAY_FRAMES - 1)) begin
        // q < lvl here, so lvl is at least 1 and cannot underflow.
        lvl_d[idx_q]  = lvl_q[idx_q] - LEVEL_W'(1);
        dcnt_d[idx_q] = '0;
      end else begin
        dcnt_d[idx_q] = dcnt_q[idx_q] + DCNT_W'(1);
      end
      peak_d[idx_q] = '0;
    end
  end

  // Pack levels with channel 0 in the most significant nibble.
  always_comb begin
    packed_lvl = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      packed_lvl[(NUM_CH - 1 - i) * LEVEL_W +: LEVEL_W] = lvl_q[i];
    end
  end

  // State, per-channel arrays, published word and sticky overrun flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ACCUM;
      idx_q     <= '0;
      sound_q   <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        peak_q[i] <= '0;
        lvl_q[i]  <= '0;
        dcnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      peak_q  <= peak_d;
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      if (state_q == PUBLISH) sound_q <= packed_lvl;
      if (frame_edge && (state_q != ACCUM)) overrun_q <= 1'b1;
    end
  end

  // Levels are final during PUBLISH, so the new word is shown alongside the
  // valid pulse and then held by sound_q until the next PUBLISH.
  assign sound_data  = (state_q == PUBLISH) ? packed_lvl : sound_q;
  assign level_valid = (state_q == PUBLISH);
  assign overrun     = overrun_q;

endmodule
